// File: rtl/resp_misr_compactor_if.sv
// Response word handshake between the upstream combinational logic and the compactor.
// Latency: none, wires only.
// Backpressure: producer holds in_valid/in_data until it sees in_ready high.
interface resp_misr_compactor_if #(
  parameter int W_IN = 10
) ();
  logic            in_valid;
  logic [W_IN-1:0] in_data;
  logic            in_ready;

  // Producer side: upstream logic or stimulus source.
  modport master (output in_valid, output in_data, input in_ready);
  // Consumer side: the compactor.
  modport slave (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/resp_misr_compactor.sv
// Folds upstream response words into a MISR signature over a fixed-length run and flags done/match.
// Latency: accepted word is reflected in sig/count one cycle later; 1 word/cycle throughput.
// Backpressure: in_ready is high only while running; it depends only on state, never on in_valid.
module resp_misr_compactor #(
  parameter int              W_IN    = 10,
  parameter int              W_SIG   = 16,
  parameter logic [W_SIG-1:0] POLY   = 16'h1021,
  parameter int              NUM_VEC = 128,
  parameter int              W_CNT   = $clog2(NUM_VEC + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   clear,
  input  logic [W_SIG-1:0]       seed,
  input  logic [W_SIG-1:0]       golden,
  resp_misr_compactor_if.slave   in_if,
  output logic [W_SIG-1:0]       sig,
  output logic [W_CNT-1:0]       count,
  output logic                   done,
  output logic                   match
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Count value held just before the final word of a run is accepted.
  localparam logic [W_CNT-1:0] LAST_CNT = W_CNT'(NUM_VEC - 1);

  state_t           state;
  state_t           state_nxt;
  logic [W_SIG-1:0] sig_nxt;
  logic [W_CNT-1:0] count_nxt;
  logic             done_nxt;
  logic             accept;

  // One MISR step: shift left, fold the polynomial back on carry-out, xor in the zero-extended word.
  function automatic logic [W_SIG-1:0] misr_step(input logic [W_SIG-1:0] s,
                                                 input logic [W_IN-1:0]  d);
    logic [W_SIG-1:0] r;
    r = {s[W_SIG-2:0], 1'b0};
    if (s[W_SIG-1]) begin
      r = r ^ POLY;
    end
    r = r ^ W_SIG'(d);
    return r;
  endfunction

  // Ready is a pure function of state so the producer never sees a combinational loop.
  assign in_if.in_ready = (state == RUN);

  // Clear inside RUN suppresses the accept even when in_valid is high.
  assign accept = (state == RUN) && !clear && in_if.in_valid;

  // Next-state and datapath updates; everything holds unless a case below changes it.
  always_comb begin
    state_nxt = state;
    sig_nxt   = sig;
    count_nxt = count;
    done_nxt  = done;
    case (state)
      IDLE: begin
        if (!clear && start) begin
          sig_nxt   = seed;
          count_nxt = '0;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (clear) begin
          state_nxt = IDLE;
        end else if (accept) begin
          sig_nxt   = misr_step(sig, in_if.in_data);
          count_nxt = count + 1'b1;
          if (count == LAST_CNT) begin
            state_nxt = DONE;
            done_nxt  = 1'b1;
          end
        end
      end
      DONE: begin
        if (clear) begin
          done_nxt  = 1'b0;
          state_nxt = IDLE;
        end else if (start) begin
          sig_nxt   = seed;
          count_nxt = '0;
          done_nxt  = 1'b0;
          state_nxt = RUN;
        end
      end
      default: begin
        state_nxt = IDLE;
        done_nxt  = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset wipes any partial run immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sig   <= '0;
      count <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      sig   <= sig_nxt;
      count <= count_nxt;
      done  <= done_nxt;
    end
  end

  // Match is only meaningful once the run has finished.
  assign match = done && (sig == golden);

endmodule

// File: tb/tb_resp_misr_compactor.sv
// Directed bench for resp_misr_compactor: four instances cover run lengths 1, 2, 8 and 128.
// Expected signatures come from a bench-side MISR model through a scoreboard queue.
// Inputs change 1 time unit after the rising edge; outputs are sampled at that point.
module tb_resp_misr_compactor;

  typedef struct {
    logic [15:0] sig;
    logic [7:0]  cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_pass = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  // Instance A: NUM_VEC=1
  logic a_start = 0, a_clear = 0, a_done, a_match;
  logic [15:0] a_seed = 0, a_golden = 0, a_sig;
  logic [0:0]  a_count;
  resp_misr_compactor_if #(.W_IN(10)) a_if ();
  resp_misr_compactor #(.NUM_VEC(1)) dut_a (
    .clk(clk), .rst(rst), .start(a_start), .clear(a_clear), .seed(a_seed), .golden(a_golden),
    .in_if(a_if), .sig(a_sig), .count(a_count), .done(a_done), .match(a_match));

  // Instance B: NUM_VEC=2
  logic b_start = 0, b_clear = 0, b_done, b_match;
  logic [15:0] b_seed = 0, b_golden = 0, b_sig;
  logic [1:0]  b_count;
  resp_misr_compactor_if #(.W_IN(10)) b_if ();
  resp_misr_compactor #(.NUM_VEC(2)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .clear(b_clear), .seed(b_seed), .golden(b_golden),
    .in_if(b_if), .sig(b_sig), .count(b_count), .done(b_done), .match(b_match));

  // Instance C: NUM_VEC=128
  logic c_start = 0, c_clear = 0, c_done, c_match;
  logic [15:0] c_seed = 0, c_golden = 0, c_sig;
  logic [7:0]  c_count;
  resp_misr_compactor_if #(.W_IN(10)) c_if ();
  resp_misr_compactor #(.NUM_VEC(128)) dut_c (
    .clk(clk), .rst(rst), .start(c_start), .clear(c_clear), .seed(c_seed), .golden(c_golden),
    .in_if(c_if), .sig(c_sig), .count(c_count), .done(c_done), .match(c_match));

  // Instance D: NUM_VEC=8, used for control, reset and backpressure
  logic d_start = 0, d_clear = 0, d_done, d_match;
  logic [15:0] d_seed = 0, d_golden = 0, d_sig;
  logic [3:0]  d_count;
  resp_misr_compactor_if #(.W_IN(10)) d_if ();
  resp_misr_compactor #(.NUM_VEC(8)) dut_d (
    .clk(clk), .rst(rst), .start(d_start), .clear(d_clear), .seed(d_seed), .golden(d_golden),
    .in_if(d_if), .sig(d_sig), .count(d_count), .done(d_done), .match(d_match));

  // Model state for instance D
  logic        d_run  = 0;
  logic        d_mdone = 0;
  logic [15:0] d_msig = 0;
  int          d_mcnt = 0;

  initial begin
    a_if.in_valid = 0; a_if.in_data = 0;
    b_if.in_valid = 0; b_if.in_data = 0;
    c_if.in_valid = 0; c_if.in_data = 0;
    d_if.in_valid = 0; d_if.in_data = 0;
  end

  // Stand-in for the 7-input/10-output upstream logic.
  function automatic logic [9:0] bench_logic(input logic [6:0] x);
    return {x[6:3] ^ x[3:0], x[2] & x[1], x[0] | x[6], ^x, x[5] ~^ x[2], x[4] & x[0], x[3] ^ x[1]};
  endfunction

  // Reference MISR step with the 16'h1021 polynomial.
  function automatic logic [15:0] misr_ref(input logic [15:0] s, input logic [9:0] d);
    logic [15:0] r;
    r = {s[14:0], 1'b0};
    if (s[15]) r = r ^ 16'h1021;
    r = r ^ {6'd0, d};
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk = n_chk + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle into instance D; model the accept, then compare after the edge.
  task automatic d_word(input string tag, input logic v, input logic [9:0] dat);
    exp_t e;
    d_if.in_valid = v;
    d_if.in_data  = dat;
    if (v && d_run) begin
      d_msig = misr_ref(d_msig, dat);
      d_mcnt = d_mcnt + 1;
      sb.push_back('{d_msig, 8'(d_mcnt)});
      if (d_mcnt == 8) begin
        d_run   = 0;
        d_mdone = 1;
      end
    end
    step();
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_sig"}, 32'(d_sig), 32'(e.sig));
      chk({tag, "_cnt"}, 32'(d_count), 32'(e.cnt));
    end else begin
      chk({tag, "_sig_hold"}, 32'(d_sig), 32'(d_msig));
      chk({tag, "_cnt_hold"}, 32'(d_count), 32'(d_mcnt));
    end
    chk({tag, "_rdy"}, 32'(d_if.in_ready), 32'(d_run));
    chk({tag, "_done"}, 32'(d_done), 32'(d_mdone));
    d_if.in_valid = 0;
  endtask

  initial begin
    exp_t e;
    logic [15:0] c_msig;

    // Reset values while rst is held
    #1;
    chk("rst_sig", 32'(d_sig), 32'h0);
    chk("rst_cnt", 32'(d_count), 32'h0);
    chk("rst_done", 32'(d_done), 32'h0);
    chk("rst_rdy", 32'(d_if.in_ready), 32'h0);
    step();
    step();
    rst = 0;

    // Single word runs, NUM_VEC=1
    a_seed = 16'hFFFF; a_start = 1;
    step();
    a_start = 0;
    chk("a_rdy", 32'(a_if.in_ready), 32'h1);
    chk("a_seed", 32'(a_sig), 32'hFFFF);
    a_if.in_valid = 1; a_if.in_data = 10'h000;
    step();
    a_if.in_valid = 0;
    chk("a0_sig", 32'(a_sig), 32'hEFDF);
    chk("a0_done", 32'(a_done), 32'h1);
    chk("a0_cnt", 32'(a_count), 32'h1);
    chk("a0_rdy", 32'(a_if.in_ready), 32'h0);
    a_start = 1;
    step();
    a_start = 0;
    chk("a_redone", 32'(a_done), 32'h0);
    chk("a_recnt", 32'(a_count), 32'h0);
    chk("a_resig", 32'(a_sig), 32'hFFFF);
    chk("a_rerdy", 32'(a_if.in_ready), 32'h1);
    a_if.in_valid = 1; a_if.in_data = 10'h3FF;
    step();
    a_if.in_valid = 0;
    chk("a1_sig", 32'(a_sig), 32'hEC20);
    chk("a1_done", 32'(a_done), 32'h1);
    a_clear = 1;
    step();
    a_clear = 0;
    chk("a_clr_done", 32'(a_done), 32'h0);
    chk("a_clr_rdy", 32'(a_if.in_ready), 32'h0);

    // Two word run, NUM_VEC=2, and the golden comparison
    b_seed = 16'h0000; b_golden = 16'h0002; b_start = 1;
    step();
    b_start = 0;
    b_if.in_valid = 1; b_if.in_data = 10'h001;
    step();
    chk("b0_sig", 32'(b_sig), 32'h0001);
    chk("b0_done", 32'(b_done), 32'h0);
    chk("b0_match", 32'(b_match), 32'h0);
    b_if.in_data = 10'h000;
    step();
    b_if.in_valid = 0;
    chk("b1_sig", 32'(b_sig), 32'h0002);
    chk("b1_cnt", 32'(b_count), 32'h2);
    chk("b1_match", 32'(b_match), 32'h1);
    b_golden = 16'h0003;
    #1;
    chk("b1_nomatch", 32'(b_match), 32'h0);

    // Control precedence on instance D
    d_seed = 16'h1234; d_start = 1;
    d_msig = 16'h1234; d_mcnt = 0; d_run = 1; d_mdone = 0;
    step();
    d_start = 0;
    d_word("ctl0", 1, bench_logic(7'd3));
    d_start = 1;
    d_word("ctl_sr", 1, bench_logic(7'd4));
    d_start = 0;
    d_word("ctl2", 1, bench_logic(7'd5));
    d_clear = 1; d_start = 1; d_if.in_valid = 1; d_if.in_data = bench_logic(7'd6);
    d_run = 0;
    step();
    d_clear = 0; d_start = 0; d_if.in_valid = 0;
    chk("clr_rdy", 32'(d_if.in_ready), 32'h0);
    chk("clr_sig", 32'(d_sig), 32'(d_msig));
    chk("clr_cnt", 32'(d_count), 32'h3);
    step();
    chk("idle_rdy", 32'(d_if.in_ready), 32'h0);

    // Reset asserted mid-run after five accepts
    d_seed = 16'h0F0F; d_start = 1;
    d_msig = 16'h0F0F; d_mcnt = 0; d_run = 1; d_mdone = 0;
    step();
    d_start = 0;
    for (int i = 0; i < 5; i++) d_word("pre_rst", 1, bench_logic(7'(i + 20)));
    d_if.in_valid = 1;
    #2;
    rst = 1;
    #1;
    chk("arst_sig", 32'(d_sig), 32'h0);
    chk("arst_cnt", 32'(d_count), 32'h0);
    chk("arst_done", 32'(d_done), 32'h0);
    chk("arst_rdy", 32'(d_if.in_ready), 32'h0);
    chk("arst_match", 32'(d_match), 32'h0);
    d_if.in_valid = 0;
    d_run = 0; d_msig = 0; d_mcnt = 0; d_mdone = 0;
    step();
    rst = 0;

    // Random valid gaps; run must still complete with the model signature
    d_seed = 16'h5A5A; d_start = 1;
    d_msig = 16'h5A5A; d_mcnt = 0; d_run = 1; d_mdone = 0;
    step();
    d_start = 0;
    chk("bp_rdy", 32'(d_if.in_ready), 32'h1);
    for (int i = 0; i < 200 && d_run; i++) begin
      d_word("bp", 1'($urandom_range(0, 1)), bench_logic(7'(i)));
    end
    chk("bp_timeout", 32'(d_run), 32'h0);
    d_golden = d_msig;
    #1;
    chk("bp_match", 32'(d_match), 32'h1);
    d_golden = d_msig ^ 16'h0100;
    #1;
    chk("bp_nomatch", 32'(d_match), 32'h0);

    // Full exhaustive run, NUM_VEC=128, continuous valid
    c_seed = 16'hACE1; c_start = 1;
    c_msig = 16'hACE1;
    step();
    c_start = 0;
    chk("c_rdy", 32'(c_if.in_ready), 32'h1);
    for (int i = 0; i < 128; i++) begin
      c_if.in_valid = 1;
      c_if.in_data  = bench_logic(7'(i));
      c_msig = misr_ref(c_msig, bench_logic(7'(i)));
      sb.push_back('{c_msig, 8'(i + 1)});
      step();
      e = sb.pop_front();
      chk("c_sig", 32'(c_sig), 32'(e.sig));
      chk("c_cnt", 32'(c_count), 32'(e.cnt));
      chk("c_done", 32'(c_done), 32'(i == 127));
    end
    c_if.in_valid = 0;
    chk("c_end_rdy", 32'(c_if.in_ready), 32'h0);
    c_golden = c_msig;
    #1;
    chk("c_match", 32'(c_match), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
